// File: rtl/sel_arith_pkg.sv
// Shared definitions for the select/increment arithmetic pipeline.
// Mode encoding matches the legacy 2-bit select inputs of the gate-level cells.
package sel_arith_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_INC  = 2'b00,
        MODE_DEC  = 2'b01,
        MODE_NEG  = 2'b10,
        MODE_PASS = 2'b11
    } mode_e;

endpackage

// File: rtl/sel_arith_core.sv
// Combinational operator: increment, decrement, two's-complement negate or pass,
// with overflow detection and optional saturation.
module sel_arith_core
    import sel_arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter bit SAT   = 1'b0
) (
    input  logic [WIDTH-1:0] a,
    input  mode_e            mode,
    output logic [WIDTH-1:0] res,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

    // Wrapped results fall out of modular arithmetic; saturation only overrides them.
    always_comb begin
        res = a;
        ovf = 1'b0;
        unique case (mode)
            MODE_INC: begin
                ovf = (a == '1);
                res = a + WIDTH'(1);
                if (SAT && ovf) res = '1;
            end
            MODE_DEC: begin
                ovf = (a == '0);
                res = a - WIDTH'(1);
                if (SAT && ovf) res = '0;
            end
            MODE_NEG: begin
                ovf = (a == MIN_NEG);
                res = '0 - a;
                if (SAT && ovf) res = MAX_POS;
            end
            default: begin
                res = a;
                ovf = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sel_arith_pipe.sv
// Two-stage valid/ready pipeline around sel_arith_core with a completed-beat counter.
// S1 holds the operand and mode, S2 holds the registered result driven onto out_*.
module sel_arith_pipe
    import sel_arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter bit SAT   = 1'b0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_ovf,
    output logic [CNT_W-1:0] beat_cnt
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    mode_e            s1_mode;
    logic             s2_valid;
    logic [WIDTH-1:0] s2_res;
    logic             s2_ovf;
    logic [WIDTH-1:0] core_res;
    logic             core_ovf;
    logic             s1_adv;
    logic             s2_adv;

    always_comb begin
        s2_adv   = !s2_valid || out_ready;
        s1_adv   = s1_valid && s2_adv;
        in_ready = !s1_valid || s2_adv;
    end

    sel_arith_core #(
        .WIDTH (WIDTH),
        .SAT   (SAT)
    ) u_core (
        .a    (s1_a),
        .mode (s1_mode),
        .res  (core_res),
        .ovf  (core_ovf)
    );

    // Data registers only load on an actual move so held outputs stay stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_mode  <= MODE_INC;
            s2_valid <= 1'b0;
            s2_res   <= '0;
            s2_ovf   <= 1'b0;
            beat_cnt <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (in_valid && in_ready) begin
                s1_a    <= in_a;
                s1_mode <= mode_e'(in_mode);
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
            end
            if (s1_adv) begin
                s2_res <= core_res;
                s2_ovf <= core_ovf;
            end
            if (s2_valid && out_ready) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        out_valid = s2_valid;
        out_res   = s2_res;
        out_ovf   = s2_ovf;
    end

endmodule
